gf8_divider: RTL and testbench

- Sequential GF(2^M) divider: computes q = a / b = a * b^-1 over the field defined by POLY. Default is GF(2^3) with P(x) = x^3 + x^2 + 1.
- It is the inverse operation to the team's combinational GF(2^3) Mastrovito multiplier. It recovers an operand from a product and a known factor.
- b^-1 is formed as b^(2^M-2) by square-and-multiply. A single internal GF multiplier is time-shared, and operands and results pass through valid/ready handshakes.

---
 rtl/gf8_divider.sv | 134 +++++++++++++
 tb/tb_gf8_divider.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/gf8_divider.sv
// Sequential GF(2^M) divider: q = a * b^-1, with b^-1 = b^(2^M-2) formed by
// square-and-multiply on a single time-shared field multiplier.
module gf8_divider #(
  parameter int             M    = 3,
  parameter logic [M-1:0]   POLY = 3'b101
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] q,
  output logic         div_by_zero
);

  // state | meaning
  // IDLE  | waiting for operands, in_ready high
  // SQR   | R <= R*R for current exponent bit
  // MUL   | R <= R*B, exponent bit was one
  // FIN   | q <= R*A
  // DONE  | result presented until out_ready
  typedef enum logic [2:0] {IDLE, SQR, MUL, FIN, DONE} state_t;

  localparam int           IW  = (M > 1) ? $clog2(M) : 1;
  localparam logic [M-1:0] EXP = {{(M-1){1'b1}}, 1'b0};

  state_t          state, state_nxt;
  logic [M-1:0]    r, r_nxt;
  logic [IW-1:0]   idx, idx_nxt;
  logic [M-1:0]    a_cap, a_cap_nxt;
  logic [M-1:0]    b_cap, b_cap_nxt;
  logic [M-1:0]    q_r, q_nxt;
  logic            dbz_r, dbz_nxt;
  logic [M-1:0]    mul_x, mul_y, prod;

  // Carry-less product, then fold bits M..2M-2 back using x^M = POLY.
  function automatic logic [M-1:0] gf_mul(input logic [M-1:0] x, input logic [M-1:0] y);
    logic [2*M-2:0] p;
    p = '0;
    for (int i = 0; i < M; i++)
      if (y[i]) p = p ^ ({{(M-1){1'b0}}, x} << i);
    for (int i = 2*M-2; i >= M; i--)
      if (p[i]) begin
        p[i] = 1'b0;
        p[i-M +: M] = p[i-M +: M] ^ POLY;
      end
    return p[M-1:0];
  endfunction

  assign prod = gf_mul(mul_x, mul_y);

  always_comb begin
    state_nxt = state;
    r_nxt     = r;
    idx_nxt   = idx;
    a_cap_nxt = a_cap;
    b_cap_nxt = b_cap;
    q_nxt     = q_r;
    dbz_nxt   = dbz_r;
    mul_x     = r;
    mul_y     = r;
    case (state)
      IDLE: begin
        if (in_valid) begin
          a_cap_nxt = a;
          b_cap_nxt = b;
          if (b == '0) begin
            q_nxt     = '0;
            dbz_nxt   = 1'b1;
            state_nxt = DONE;
          end else begin
            r_nxt     = M'(1);
            idx_nxt   = IW'(M-1);
            state_nxt = SQR;
          end
        end
      end
      SQR: begin
        r_nxt = prod;
        if (EXP[idx])          state_nxt = MUL;
        else if (idx == '0)    state_nxt = FIN;
        else                   idx_nxt   = idx - IW'(1);
      end
      MUL: begin
        mul_y = b_cap;
        r_nxt = prod;
        if (idx == '0) state_nxt = FIN;
        else begin
          idx_nxt   = idx - IW'(1);
          state_nxt = SQR;
        end
      end
      FIN: begin
        mul_y     = a_cap;
        q_nxt     = prod;
        dbz_nxt   = 1'b0;
        state_nxt = DONE;
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      r     <= M'(1);
      idx   <= IW'(M-1);
      a_cap <= '0;
      b_cap <= '0;
      q_r   <= '0;
      dbz_r <= 1'b0;
    end else begin
      state <= state_nxt;
      r     <= r_nxt;
      idx   <= idx_nxt;
      a_cap <= a_cap_nxt;
      b_cap <= b_cap_nxt;
      q_r   <= q_nxt;
      dbz_r <= dbz_nxt;
    end
  end

  assign in_ready    = (state == IDLE);
  assign out_valid   = (state == DONE);
  assign q           = q_r;
  assign div_by_zero = dbz_r;

endmodule

// File: tb/tb_gf8_divider.sv
// Directed bench for gf8_divider over GF(2^3), P(x) = x^3 + x^2 + 1.
module tb_gf8_divider;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] a, b;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] q;
  logic       div_by_zero;

  int vectors = 0;
  int fails   = 0;

  gf8_divider #(.M(3), .POLY(3'b101)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .q(q), .div_by_zero(div_by_zero)
  );

  always #5 clk = ~clk;

  // Shift-and-add reference multiply: x*alpha reduces via x^3 = x^2 + 1.
  function automatic logic [2:0] ref_mul(input logic [2:0] x, input logic [2:0] y);
    logic [2:0] acc, t;
    acc = 3'b000;
    t   = x;
    for (int i = 0; i < 3; i++) begin
      if (y[i]) acc = acc ^ t;
      t = t[2] ? ({t[1:0], 1'b0} ^ 3'b101) : {t[1:0], 1'b0};
    end
    return acc;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one operand pair, measure edges from accept to out_valid, check result, handshake.
  task automatic run_op(input logic [2:0] ai, input logic [2:0] bi, input logic [2:0] eq,
                        input logic edbz, input int elat, input string tag);
    int n;
    @(negedge clk);
    chk({tag, " in_ready"}, 32'(in_ready), 32'd1);
    a = ai; b = bi; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(elat));
    chk({tag, " q"}, 32'(q), 32'(eq));
    chk({tag, " dbz"}, 32'(div_by_zero), 32'(edbz));
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk({tag, " post in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, " post out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    logic [2:0] exp_q;
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset out_valid", 32'(out_valid), 32'd0);
    chk("reset in_ready", 32'(in_ready), 32'd1);
    chk("reset q", 32'(q), 32'd0);
    chk("reset dbz", 32'(div_by_zero), 32'd0);
    @(negedge clk); rst = 1'b0;

    run_op(3'b001, 3'b010, 3'b110, 1'b0, 6, "inv2");
    run_op(3'b011, 3'b101, 3'b100, 1'b0, 6, "div3_5");
    run_op(3'b111, 3'b111, 3'b001, 1'b0, 6, "div7_7");
    run_op(3'b101, 3'b000, 3'b000, 1'b1, 0, "divzero");
    run_op(3'b110, 3'b001, 3'b110, 1'b0, 6, "after_zero");

    // Sweep: expected quotient is the unique x with x*b == a under the reference multiply.
    for (int ai = 0; ai < 8; ai++)
      for (int bi = 1; bi < 8; bi++) begin
        exp_q = 3'b000;
        for (int x = 0; x < 8; x++)
          if (ref_mul(3'(x), 3'(bi)) == 3'(ai)) exp_q = 3'(x);
        run_op(3'(ai), 3'(bi), exp_q, 1'b0, 6, $sformatf("sweep a=%0d b=%0d", ai, bi));
      end

    // Backpressure with ignored operands while the result is pending.
    @(negedge clk);
    a = 3'b011; b = 3'b101; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("bp out_valid", 32'(out_valid), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (c == 1) begin a = 3'b111; b = 3'b000; in_valid = 1'b1; end
      else in_valid = 1'b0;
      @(posedge clk); #1;
      chk($sformatf("bp hold q c%0d", c), 32'(q), 32'd4);
      chk($sformatf("bp hold valid c%0d", c), 32'(out_valid), 32'd1);
      chk($sformatf("bp hold dbz c%0d", c), 32'(div_by_zero), 32'd0);
      chk($sformatf("bp in_ready c%0d", c), 32'(in_ready), 32'd0);
    end
    @(negedge clk); in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("bp release in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    chk("bp no stray op", 32'(in_ready), 32'd1);

    // Reset in the third cycle of a computation.
    @(negedge clk);
    a = 3'b010; b = 3'b011; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    chk("midrst q", 32'(q), 32'd0);
    @(negedge clk); rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      chk($sformatf("midrst no stale c%0d", c), 32'(out_valid), 32'd0);
    end
    run_op(3'b001, 3'b100, 3'b011, 1'b0, 6, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
